// File: rtl/instr_ctrl_if.sv
// Instruction controller bus: instruction/handshake inputs toward the
// controller and datapath control outputs back from it.
interface instr_ctrl_if;
  logic        load;
  logic        s;
  logic [15:0] in;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;

  modport master (
    output load, s, in,
    input  w, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, ALUop, sximm8
  );

  modport slave (
    input  load, s, in,
    output w, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, ALUop, sximm8
  );
endinterface

// File: rtl/instr_ctrl.sv
// Instruction register, field decoder and multi-cycle sequencing FSM that
// steps the register file, A/B/C/status registers and ALU for each instruction.
module instr_ctrl (
  input  logic         clk,
  input  logic         reset,
  instr_ctrl_if.slave  bus
);
  localparam int unsigned IW = 16;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE_REG
  } state_t;

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic [1:0] shift;
    logic [1:0] aluop;
  } ctrl_t;

  state_t        r_state;
  logic [IW-1:0] r_ir;
  ctrl_t         r_ctrl;

  logic [IW-1:0] w_ir_next;
  state_t        w_state_next;
  ctrl_t         w_ctrl;

  // Next state from current state, opcode/op field and the start request.
  function automatic state_t next_state(input state_t st, input logic [4:0] opf,
                                        input logic start);
    logic [2:0] opc;
    logic [1:0] op;
    opc = opf[4:2];
    op  = opf[1:0];
    next_state = S_WAIT;
    case (st)
      S_WAIT:   next_state = start ? S_DECODE : S_WAIT;
      S_DECODE: begin
        if (opc == OPC_MOV && op == 2'b10)      next_state = S_WRITE_IMM;
        else if (opc == OPC_MOV && op == 2'b00) next_state = S_GET_B;
        else if (opc == OPC_ALU)                next_state = (op == 2'b11) ? S_GET_B : S_GET_A;
        else                                    next_state = S_WAIT;
      end
      S_GET_A:  next_state = S_GET_B;
      S_GET_B:  next_state = S_EXEC;
      S_EXEC:   next_state = (opc == OPC_ALU && op == 2'b01) ? S_WAIT : S_WRITE_REG;
      default:  next_state = S_WAIT;
    endcase
  endfunction

  // Moore control decode for a given state and instruction word.
  function automatic ctrl_t ctrl_for(input state_t st, input logic [IW-1:0] ir);
    ctrl_t c;
    c = '0;
    case (st)
      S_WAIT:      c.w = 1'b1;
      S_WRITE_IMM: begin
        c.write    = 1'b1;
        c.writenum = ir[10:8];
        c.vsel     = 2'b10;
      end
      S_GET_A: begin
        c.readnum = ir[10:8];
        c.loada   = 1'b1;
      end
      S_GET_B: begin
        c.readnum = ir[2:0];
        c.loadb   = 1'b1;
      end
      S_EXEC: begin
        c.shift = ir[4:3];
        c.aluop = ir[12:11];
        // MOV Rd,Rm is computed as 0 + shifted Rm.
        if (ir[15:13] == OPC_MOV) begin
          c.aluop = 2'b00;
          c.asel  = 1'b1;
        end
        if (ir[15:13] == OPC_ALU && ir[12:11] == 2'b01) c.loads = 1'b1;
        else                                            c.loadc = 1'b1;
      end
      S_WRITE_REG: begin
        c.write    = 1'b1;
        c.writenum = ir[7:5];
        c.vsel     = 2'b00;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign w_ir_next    = (r_state == S_WAIT && bus.load) ? bus.in : r_ir;
  assign w_state_next = next_state(r_state, w_ir_next[15:11], bus.s);

  // Controls are registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
      r_ctrl  <= ctrl_for(S_WAIT, '0);
    end else begin
      r_state <= w_state_next;
      r_ir    <= w_ir_next;
      r_ctrl  <= ctrl_for(w_state_next, w_ir_next);
    end
  end

  // Reset holds every control output low while asserted.
  assign w_ctrl = reset ? '0 : r_ctrl;

  assign bus.w        = w_ctrl.w;
  assign bus.readnum  = w_ctrl.readnum;
  assign bus.writenum = w_ctrl.writenum;
  assign bus.write    = w_ctrl.write;
  assign bus.loada    = w_ctrl.loada;
  assign bus.loadb    = w_ctrl.loadb;
  assign bus.loadc    = w_ctrl.loadc;
  assign bus.loads    = w_ctrl.loads;
  assign bus.asel     = w_ctrl.asel;
  assign bus.bsel     = w_ctrl.bsel;
  assign bus.vsel     = w_ctrl.vsel;
  assign bus.shift    = w_ctrl.shift;
  assign bus.ALUop    = w_ctrl.aluop;
  assign bus.sximm8   = {{8{r_ir[7]}}, r_ir[7:0]};
endmodule

// File: tb/tb_instr_ctrl.sv
// Self-checking bench for instr_ctrl: per-cycle expected control table fed
// through a scoreboard, plus hand sequences for reset and IR protection.
module tb_instr_ctrl;
  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic [4:0] strb;   // {write, loada, loadb, loadc, loads}
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic [1:0] shift;
    logic [1:0] aluop;
  } ctl_t;

  typedef struct packed {
    logic        first;
    logic [15:0] instr;
    ctl_t        c;
    logic [15:0] sx;
  } step_t;

  localparam logic [4:0] NO = 5'b00000;
  localparam logic [4:0] WR = 5'b10000;
  localparam logic [4:0] LA = 5'b01000;
  localparam logic [4:0] LB = 5'b00100;
  localparam logic [4:0] LC = 5'b00010;
  localparam logic [4:0] LS = 5'b00001;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  step_t tbl[$];
  step_t sb[$];
  ctl_t  dec_c, wait_c, zero_c;

  instr_ctrl_if ifc ();

  instr_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  function automatic ctl_t mk(input logic w, input logic [2:0] rn, input logic [2:0] wn,
                              input logic [4:0] strb, input logic asel,
                              input logic [1:0] vsel, input logic [1:0] sh,
                              input logic [1:0] alu);
    return {w, rn, wn, strb, asel, 1'b0, vsel, sh, alu};
  endfunction

  function automatic ctl_t dut_ctl();
    return {ifc.w, ifc.readnum, ifc.writenum,
            {ifc.write, ifc.loada, ifc.loadb, ifc.loadc, ifc.loads},
            ifc.asel, ifc.bsel, ifc.vsel, ifc.shift, ifc.ALUop};
  endfunction

  task automatic add(input logic first, input logic [15:0] instr, input ctl_t c,
                     input logic [15:0] sx);
    tbl.push_back({first, instr, c, sx});
  endtask

  task automatic check_ctl(input string name, input ctl_t exp);
    ctl_t got;
    got = dut_ctl();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: ctl got=%05h exp=%05h", name, got, exp);
    end
  endtask

  task automatic check_sx(input string name, input logic [15:0] exp);
    checks++;
    if (ifc.sximm8 !== exp) begin
      failures++;
      $display("FAIL %s: sximm8 got=%04h exp=%04h", name, ifc.sximm8, exp);
    end
  endtask

  task automatic check_step(input string name);
    step_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check_ctl(name, e.c);
      check_sx(name, e.sx);
    end
  endtask

  function automatic int steps_from(input int i);
    int n;
    n = 1;
    while (i + n < tbl.size() && !tbl[i + n].first) n++;
    return n;
  endfunction

  function automatic int find_instr(input logic [15:0] v);
    for (int i = 0; i < tbl.size(); i++)
      if (tbl[i].first && tbl[i].instr == v) return i;
    return 0;
  endfunction

  task automatic push_range(input int i, input int n);
    for (int k = 0; k < n; k++) sb.push_back(tbl[i + k]);
  endtask

  task automatic load_ir(input logic [15:0] v);
    @(negedge clk);
    ifc.load = 1'b1;
    ifc.in   = v;
  endtask

  task automatic start();
    @(negedge clk);
    ifc.load = 1'b0;
    ifc.s    = 1'b1;
  endtask

  task automatic run_steps(input int n, input int clr_at, input string name);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (k == clr_at) begin
        ifc.s    = 1'b0;
        ifc.load = 1'b0;
      end
      check_step($sformatf("%s_e%0d", name, k + 1));
    end
  endtask

  initial begin
    int i, n, idx_add;
    ctl_t tmp;

    dec_c  = mk(0, 0, 0, NO, 0, 2'b00, 2'b00, 2'b00);
    wait_c = mk(1, 0, 0, NO, 0, 2'b00, 2'b00, 2'b00);
    zero_c = '0;

    // MOV R0,#-3
    add(1, 16'hD0FD, dec_c, 16'hFFFD);
    add(0, 16'hD0FD, mk(0, 0, 0, WR, 0, 2'b10, 2'b00, 2'b00), 16'hFFFD);
    add(0, 16'hD0FD, wait_c, 16'hFFFD);
    // ADD R2,R1,R0,LSL#1
    add(1, 16'hA148, dec_c, 16'h0048);
    add(0, 16'hA148, mk(0, 1, 0, LA, 0, 2'b00, 2'b00, 2'b00), 16'h0048);
    add(0, 16'hA148, mk(0, 0, 0, LB, 0, 2'b00, 2'b00, 2'b00), 16'h0048);
    add(0, 16'hA148, mk(0, 0, 0, LC, 0, 2'b00, 2'b01, 2'b00), 16'h0048);
    add(0, 16'hA148, mk(0, 0, 2, WR, 0, 2'b00, 2'b00, 2'b00), 16'h0048);
    add(0, 16'hA148, wait_c, 16'h0048);
    // CMP R1,R0
    add(1, 16'hA900, dec_c, 16'h0000);
    add(0, 16'hA900, mk(0, 1, 0, LA, 0, 2'b00, 2'b00, 2'b00), 16'h0000);
    add(0, 16'hA900, mk(0, 0, 0, LB, 0, 2'b00, 2'b00, 2'b00), 16'h0000);
    add(0, 16'hA900, mk(0, 0, 0, LS, 0, 2'b00, 2'b00, 2'b01), 16'h0000);
    add(0, 16'hA900, wait_c, 16'h0000);
    // MVN R3,R2
    add(1, 16'hB862, dec_c, 16'h0062);
    add(0, 16'hB862, mk(0, 2, 0, LB, 0, 2'b00, 2'b00, 2'b00), 16'h0062);
    add(0, 16'hB862, mk(0, 0, 0, LC, 0, 2'b00, 2'b00, 2'b11), 16'h0062);
    add(0, 16'hB862, mk(0, 0, 3, WR, 0, 2'b00, 2'b00, 2'b00), 16'h0062);
    add(0, 16'hB862, wait_c, 16'h0062);
    // undefined
    add(1, 16'h0000, dec_c, 16'h0000);
    add(0, 16'h0000, wait_c, 16'h0000);
    // MOV R6,R1,LSR#1
    add(1, 16'hC0D1, dec_c, 16'hFFD1);
    add(0, 16'hC0D1, mk(0, 1, 0, LB, 0, 2'b00, 2'b00, 2'b00), 16'hFFD1);
    add(0, 16'hC0D1, mk(0, 0, 0, LC, 1, 2'b00, 2'b10, 2'b00), 16'hFFD1);
    add(0, 16'hC0D1, mk(0, 0, 6, WR, 0, 2'b00, 2'b00, 2'b00), 16'hFFD1);
    add(0, 16'hC0D1, wait_c, 16'hFFD1);
    // AND R4,R3,R5,ASR#1
    add(1, 16'hB39D, dec_c, 16'hFF9D);
    add(0, 16'hB39D, mk(0, 3, 0, LA, 0, 2'b00, 2'b00, 2'b00), 16'hFF9D);
    add(0, 16'hB39D, mk(0, 5, 0, LB, 0, 2'b00, 2'b00, 2'b00), 16'hFF9D);
    add(0, 16'hB39D, mk(0, 0, 0, LC, 0, 2'b00, 2'b11, 2'b10), 16'hFF9D);
    add(0, 16'hB39D, mk(0, 0, 4, WR, 0, 2'b00, 2'b00, 2'b00), 16'hFF9D);
    add(0, 16'hB39D, wait_c, 16'hFF9D);
    // undefined: MOV opcode with op 01, and opcode 111
    add(1, 16'hC800, dec_c, 16'h0000);
    add(0, 16'hC800, wait_c, 16'h0000);
    add(1, 16'hE000, dec_c, 16'h0000);
    add(0, 16'hE000, wait_c, 16'h0000);

    ifc.load = 1'b0;
    ifc.s    = 1'b0;
    ifc.in   = 16'h0000;
    reset    = 1'b1;

    // Reset forces controls low, then WAIT with a cleared IR.
    #1;
    check_ctl("reset_hold", zero_c);
    @(posedge clk);
    #1;
    check_ctl("reset_hold_edge", zero_c);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_ctl("post_reset", wait_c);
    check_sx("post_reset", 16'h0000);

    // Table-driven instruction sequences.
    i = 0;
    while (i < tbl.size()) begin
      n = steps_from(i);
      load_ir(tbl[i].instr);
      start();
      push_range(i, n);
      run_steps(n, 0, $sformatf("instr_%04h", tbl[i].instr));
      i += n;
    end

    // load and s together: new IR is decoded immediately.
    @(negedge clk);
    ifc.load = 1'b1;
    ifc.s    = 1'b1;
    ifc.in   = 16'hD0FD;
    push_range(0, 3);
    run_steps(3, 0, "load_and_s");

    // s held high restarts from WAIT on the following edge.
    load_ir(16'h0000);
    start();
    tmp = dec_c;
    sb.push_back({1'b1, 16'h0000, tmp, 16'h0000});
    sb.push_back({1'b0, 16'h0000, wait_c, 16'h0000});
    sb.push_back({1'b0, 16'h0000, tmp, 16'h0000});
    sb.push_back({1'b0, 16'h0000, wait_c, 16'h0000});
    run_steps(4, 2, "s_held");

    // Reset during EXEC of ADD abandons it and clears IR.
    idx_add = find_instr(16'hA148);
    load_ir(16'hA148);
    start();
    push_range(idx_add, 4);
    run_steps(4, 0, "add_to_exec");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_ctl("reset_in_exec", zero_c);
    @(posedge clk);
    #1;
    check_ctl("reset_in_exec_edge", zero_c);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_ctl("after_exec_reset", wait_c);
    check_sx("after_exec_reset", 16'h0000);
    @(negedge clk);
    ifc.s = 1'b1;
    sb.push_back({1'b1, 16'h0000, dec_c, 16'h0000});
    sb.push_back({1'b0, 16'h0000, wait_c, 16'h0000});
    run_steps(2, 0, "ir_cleared");

    // load during GET_B must not disturb IR.
    load_ir(16'hA148);
    start();
    push_range(idx_add, 6);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) ifc.s = 1'b0;
      if (k == 3) ifc.load = 1'b0;
      check_step($sformatf("ir_protect_e%0d", k + 1));
      if (k == 2) begin
        @(negedge clk);
        ifc.load = 1'b1;
        ifc.in   = 16'hD0FD;
      end
    end

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: left=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_ctrl.md
# instr_ctrl

Instruction register, decoder and sequencing FSM for the lab datapath. It sits directly upstream of the ALU and its operand path. It captures a 16-bit instruction and decodes its fields. For each instruction it steps the register file, the A/B/C/status registers and the ALU through a fixed multi-cycle sequence. It drives `ALUop`, `shift`, the operand selects and all load/write strobes, and reports `w` when idle.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  rising-edge clock for every state element
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `load`  in  1  capture `in` into IR (honoured in WAIT only)
- `s`  in  1  start execution of IR (sampled in WAIT only, level-sensitive)
- `in`  in  16  instruction word
- `w`  out  1  1 when FSM is in WAIT
- `readnum`  out  3  register-file read index
- `writenum`  out  3  register-file write index
- `write`  out  1  register-file write enable
- `loada`, `loadb`, `loadc`, `loads`  out  1 each  A, B, C and status register enables
- `asel`  out  1  1 = ALU A operand forced to 16'h0000
- `bsel`  out  1  1 = ALU B operand from sximm5 (never driven 1 by this block)
- `vsel`  out  2  writeback source: 00 = C, 10 = sximm8; 01 and 11 are never driven
- `shift`  out  2  shifter control to the B path
- `ALUop`  out  2  ALU operation
- `sximm8`  out  16  IR[7:0] sign-extended

## Operation
- IR fields: opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- sximm8 = {{8{IR[7]}}, IR[7:0]}, driven combinationally at all times.
- FSM states: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG.
- All control outputs are Moore decodes of the state and IR.
- Any output not listed as asserted for a state is 0, including readnum and writenum.
- WAIT:
  - w = 1.
  - `load` = 1 sets IR <= in.
  - `s` = 1 moves the FSM to DECODE.
- DECODE selects the next state:
  - MOV Rn,#imm8 (110, op 10): WRITE_IMM.
  - MOV Rd,Rm{,sh} (110, op 00): GET_B.
  - ADD, CMP, AND (101, op 00/01/10): GET_A.
  - MVN (101, op 11): GET_B.
  - Any other opcode/op combination: WAIT, with no strobe asserted.
- WRITE_IMM asserts write = 1, writenum = Rn, vsel = 10; next state WAIT.
- GET_A asserts readnum = Rn, loada = 1; next state GET_B.
- GET_B asserts readnum = Rm, loadb = 1; next state EXEC.
- EXEC:
  - shift = sh.
  - ALUop = op; for MOV Rd,Rm, ALUop = 00 and asel = 1 (result = 0 + shifted Rm).
  - CMP: loads = 1, loadc = 0, next state WAIT.
  - All other instructions: loadc = 1, next state WRITE_REG.
- WRITE_REG asserts write = 1, writenum = Rd, vsel = 00; next state WAIT.
- `shift` is 00 in every state except EXEC.

## Timing
- Reset:
  - While reset = 1, all outputs except sximm8 are forced to 0.
  - At the clocking edge, state <= WAIT and IR <= 16'h0000.
  - After that edge: w = 1, sximm8 = 0.
  - Reset mid-instruction abandons the sequence; no write or load strobe occurs in the cycle after reset.
- Latency, counted in edges from the edge that samples s = 1 until w returns to 1:
  - MOV imm: 3
  - undefined instruction: 2
  - MOV reg and MVN: 5
  - ADD and AND: 6
  - CMP: 5
- Strobe/capture relationship:
  - Every strobe is high for exactly one cycle.
  - Registers downstream capture on the edge that ends that cycle.
  - The ALU result is valid combinationally during EXEC.
- `load` and `s` outside WAIT are ignored. IR is stable for the whole instruction.
- `load` and `s` high together in WAIT:
  - IR updates on that edge and the FSM enters DECODE.
  - DECODE uses the new IR.
- `s` still high on return to WAIT starts the next instruction on the following edge.

## Test plan
- Reset, then load 0xD0FD (MOV R0,#-3), pulse s:
  - DECODE, then WRITE_IMM with write = 1, writenum = 0, vsel = 10, sximm8 = 0xFFFD.
  - w = 1 at edge 3.
- Load 0xA148 (ADD R2,R1,R0,LSL#1):
  - GET_A with readnum = 1, loada = 1.
  - GET_B with readnum = 0, loadb = 1.
  - EXEC with ALUop = 00, shift = 01, loadc = 1.
  - WRITE_REG with writenum = 2, vsel = 00.
  - w = 1 at edge 6.
- Load 0xA900 (CMP R1,R0): EXEC has ALUop = 01, loads = 1, loadc = 0; write is never 1; w = 1 at edge 5.
- Load 0xB862 (MVN R3,R2):
  - GET_B with readnum = 2.
  - EXEC with ALUop = 11.
  - WRITE_REG with writenum = 3.
  - loada never 1.
- Load 0x0000 (undefined) and pulse s: DECODE, then WAIT; no strobe is asserted.
- Reset and IR protection during an ADD:
  - Assert reset during EXEC: next cycle is WAIT, IR = 0, write = 0.
  - Separately, pulse load with in = 0xD0FD during GET_B: IR is unchanged.
